// File: rtl/engine_result_arbiter.sv
// rtl/engine_result_arbiter.sv - round-robin drain of engine results into the VGA frame buffer
// Grants one engine per two cycles, registers its word, and writes itr to address x + y*H_RES.
module engine_result_arbiter #(
  parameter int NUM_PROC = 12,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                clk_iCLK,
  input  logic                iRST_N,
  input  logic [NUM_PROC-1:0] engine_req,
  output logic [NUM_PROC-1:0] req_ack,
  input  logic [26:0]         eng_word,
  input  logic                frame_start,
  output logic                ram_wr_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [7:0]          ram_data,
  output logic                frame_done,
  output logic                coord_err,
  output logic [ADDR_W-1:0]   pix_count
);

  localparam int                IDX_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PROC - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [NUM_PROC-1:0] req_m;
  logic                found;
  logic [IDX_W-1:0]    pick;
  logic                wr;

  logic [9:0] eng_x;
  logic [8:0] eng_y;
  logic [7:0] eng_itr;
  logic       coord_ok;

  assign eng_x    = eng_word[26:17];
  assign eng_y    = eng_word[16:8];
  assign eng_itr  = eng_word[7:0];
  assign coord_ok = (32'(eng_x) < H_RES) && (32'(eng_y) < V_RES);

  // The engine just acked may still hold its request during WRITE, so it is masked there.
  always_comb begin : rr_pick
    int idx;
    req_m = engine_req;
    if (state_q == S_WRITE) req_m[last_q] = 1'b0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      idx = int'(last_q) + 1 + i;
      if (idx >= NUM_PROC) idx = idx - NUM_PROC;
      if (!found && req_m[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      last_q  <= LAST_IDX;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_GRANT;
      S_GRANT: state_d = S_WRITE;
      S_WRITE: state_d = found ? S_GRANT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : datapath_next
    win_d   = win_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (state_q != S_GRANT && found) win_d = pick;
    if (state_q == S_GRANT) begin
      last_d  = win_q;
      addr_d  = ADDR_W'(eng_x) + ADDR_W'(eng_y) * H_RES_A;
      data_d  = eng_itr;
      valid_d = coord_ok;
      if (!coord_ok) err_d = 1'b1;
    end
  end

  always_comb begin : outputs
    req_ack = '0;
    wr      = 1'b0;
    case (state_q)
      S_GRANT: req_ack[win_q] = 1'b1;
      S_WRITE: wr = valid_q;
      default: ;
    endcase
  end

  // A coincident frame_start makes this write pixel 0 of the new frame.
  always_comb begin : pixel_next
    pix_d = pix_q;
    if (frame_start)
      pix_d = wr ? ADDR_W'(1) : '0;
    else if (wr)
      pix_d = (pix_q == LAST_PIX) ? '0 : pix_q + ADDR_W'(1);
  end

  assign frame_done = wr && !frame_start && (pix_q == LAST_PIX);
  assign ram_wr_en  = wr;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign coord_err  = err_q;
  assign pix_count  = pix_q;

endmodule

// File: tb/tb_engine_result_arbiter.sv
// tb/tb_engine_result_arbiter.sv - directed self-checking bench for engine_result_arbiter
module tb_engine_result_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] engine_req, req_ack;
  logic [26:0] eng_word;
  logic        frame_start, ram_wr_en, frame_done, coord_err;
  logic [18:0] ram_addr, pix_count;
  logic [7:0]  ram_data;

  logic [1:0]  f_req, f_ack;
  logic [26:0] f_word;
  logic        f_fs, f_wr, f_fd, f_err;
  logic [18:0] f_addr, f_pix;
  logic [7:0]  f_data;

  logic [26:0] word_tab [12];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  engine_result_arbiter dut (
    .clk_iCLK(clk), .iRST_N(rst_n), .engine_req(engine_req), .req_ack(req_ack),
    .eng_word(eng_word), .frame_start(frame_start), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_data(ram_data), .frame_done(frame_done),
    .coord_err(coord_err), .pix_count(pix_count)
  );

  engine_result_arbiter #(.NUM_PROC(2), .H_RES(4), .V_RES(3), .ADDR_W(19)) dut_f (
    .clk_iCLK(clk), .iRST_N(rst_n), .engine_req(f_req), .req_ack(f_ack),
    .eng_word(f_word), .frame_start(f_fs), .ram_wr_en(f_wr),
    .ram_addr(f_addr), .ram_data(f_data), .frame_done(f_fd),
    .coord_err(f_err), .pix_count(f_pix)
  );

  always_comb begin
    eng_word = '0;
    for (int i = 0; i < 12; i++)
      if (req_ack[i]) eng_word = word_tab[i];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [11:0] v);
    int r = -1;
    for (int i = 0; i < 12; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_single(input int idx, input int x, input int y, input int itr,
                           input logic exp_wr, input int exp_addr);
    word_tab[idx] = {10'(x), 9'(y), 8'(itr)};
    engine_req = 12'(1 << idx);
    tick;
    check_val("single_ack", 32'(req_ack), 32'(1 << idx));
    tick;
    engine_req = '0;
    check_val("single_ack_drop", 32'(req_ack), 0);
    check_val("single_wr", 32'(ram_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      check_val("single_addr", 32'(ram_addr), 32'(exp_addr));
      check_val("single_data", 32'(ram_data), 32'(itr));
    end
    tick;
    check_val("single_wr_end", 32'(ram_wr_en), 0);
  endtask

  task automatic f_write(input int i, input logic fs, output logic wr, output logic fd);
    f_word = {10'(i % 4), 9'(i / 4), 8'(i)};
    f_req  = 2'b01;
    tick;
    f_req = 2'b00;
    tick;
    f_fs = fs;
    #1;
    wr = f_wr;
    fd = f_fd;
    tick;
    f_fs = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] prev_ack;
    int ngr, nwr, last_wr, cur, rec [4];
    logic wr, fd, any_fd;
    int fwr;

    engine_req = '0; frame_start = 1'b0;
    f_req = '0; f_word = '0; f_fs = 1'b0;
    for (int i = 0; i < 12; i++) word_tab[i] = '0;
    #1;
    check_val("rst_ack", 32'(req_ack), 0);
    check_val("rst_wr", 32'(ram_wr_en), 0);
    check_val("rst_addr", 32'(ram_addr), 0);
    check_val("rst_data", 32'(ram_data), 0);
    check_val("rst_fd", 32'(frame_done), 0);
    check_val("rst_err", 32'(coord_err), 0);
    check_val("rst_pix", 32'(pix_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick;

    // all twelve engines requesting; each drops the cycle after its ack
    for (int i = 0; i < 12; i++) word_tab[i] = {10'(i * 10), 9'(i), 8'(i + 16)};
    engine_req = 12'hFFF;
    prev_ack = '0; ngr = 0; nwr = 0; last_wr = 0; cur = 0;
    for (int c = 0; c < 40 && nwr < 12; c++) begin
      @(posedge clk); #1;
      engine_req = engine_req & ~prev_ack;
      prev_ack = req_ack;
      #1;
      if (req_ack != '0) begin
        check_val("ack_onehot", 32'($countones(req_ack)), 1);
        cur = onehot_idx(req_ack);
        check_val("grant_order", 32'(cur), 32'(ngr));
        ngr++;
      end
      if (ram_wr_en) begin
        check_val("rr_addr", 32'(ram_addr), 32'(cur * 650));
        check_val("rr_data", 32'(ram_data), 32'(cur + 16));
        if (nwr > 0) check_val("wr_spacing", 32'(c - last_wr), 2);
        last_wr = c;
        nwr++;
      end
    end
    check_val("rr_writes", 32'(nwr), 12);
    engine_req = '0;
    tick;
    check_val("rr_pix", 32'(pix_count), 12);
    check_val("rr_idle_ack", 32'(req_ack), 0);

    // single request, engine 2: 5 + 2*640 = 1285
    do_single(2, 5, 2, 8'h3C, 1'b1, 1285);
    check_val("single_pix", 32'(pix_count), 13);

    // fairness: last=3, engines 0 and 3 held
    do_single(3, 30, 3, 19, 1'b1, 1950);
    engine_req = 12'h009;
    ngr = 0;
    for (int c = 0; c < 20 && ngr < 4; c++) begin
      tick;
      if (req_ack != '0) begin
        rec[ngr] = onehot_idx(req_ack);
        ngr++;
        if (ngr == 4) engine_req = '0;
      end
    end
    check_val("fair_grants", 32'(ngr), 4);
    check_val("fair_g0", 32'(rec[0]), 0);
    check_val("fair_g1", 32'(rec[1]), 3);
    check_val("fair_g2", 32'(rec[2]), 0);
    check_val("fair_g3", 32'(rec[3]), 3);
    tick;
    tick;
    check_val("fair_pix", 32'(pix_count), 18);

    // boundary coordinates
    do_single(1, 639, 479, 8'hAA, 1'b1, 307199);
    check_val("max_pix", 32'(pix_count), 19);
    check_val("max_err", 32'(coord_err), 0);
    do_single(1, 640, 0, 8'h11, 1'b0, 0);
    check_val("bad_err", 32'(coord_err), 1);
    check_val("bad_pix", 32'(pix_count), 19);
    do_single(1, 1, 1, 8'h55, 1'b1, 641);
    check_val("err_sticky", 32'(coord_err), 1);
    check_val("after_bad_pix", 32'(pix_count), 20);

    // reset asserted during GRANT
    engine_req = 12'h030;
    tick;
    check_val("pre_rst_ack", 32'(req_ack), 32'h010);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_ack", 32'(req_ack), 0);
    check_val("async_pix", 32'(pix_count), 0);
    check_val("async_err", 32'(coord_err), 0);
    tick;
    check_val("rst_no_wr", 32'(ram_wr_en), 0);
    engine_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check_val("rel_no_wr", 32'(ram_wr_en), 0);
    check_val("rel_no_ack", 32'(req_ack), 0);
    engine_req = 12'h030;
    tick;
    check_val("rel_first_ack", 32'(req_ack), 32'h010);
    tick;
    engine_req = '0;
    check_val("rel_wr", 32'(ram_wr_en), 1);
    check_val("rel_addr", 32'(ram_addr), 2600);
    tick;

    // frame counting on a 4x3 instance
    any_fd = 1'b0; fwr = 0;
    for (int i = 0; i < 11; i++) begin
      f_write(i, 1'b0, wr, fd);
      any_fd = any_fd | fd;
      fwr += int'(wr);
    end
    check_val("f_writes", 32'(fwr), 11);
    check_val("f_no_early_fd", 32'(any_fd), 0);
    check_val("f_pix11", 32'(f_pix), 11);
    f_write(11, 1'b0, wr, fd);
    check_val("f_last_wr", 32'(wr), 1);
    check_val("f_frame_done", 32'(fd), 1);
    check_val("f_pix_wrap", 32'(f_pix), 0);
    for (int i = 0; i < 11; i++) f_write(i, 1'b0, wr, fd);
    check_val("f2_pix11", 32'(f_pix), 11);
    f_write(11, 1'b1, wr, fd);
    check_val("fs_wr", 32'(wr), 1);
    check_val("fs_no_fd", 32'(fd), 0);
    check_val("fs_pix", 32'(f_pix), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/engine_result_arbiter.md
Name: engine_result_arbiter

Overview:
- Round-robin arbiter that drains iteration results from the NUM_PROC calculating engines into the VGA dual-port frame buffer. It grants one requesting engine at a time, captures that engine's 27-bit result word and converts x,y to a linear RAM address (x + y*H_RES). It then issues a single-cycle RAM write.
- Sits between the engine array and the VGA block on the engine clock domain.
- Counts pixels written and flags frame completion.

Parameters:
- NUM_PROC, 12, number of engines (1..32)
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, frame-buffer address width

Ports:
- clk_iCLK  in  1  engine clock
- iRST_N  in  1  asynchronous active-low reset
- engine_req  in  NUM_PROC  per-engine service request, level, one bit per engine
- req_ack  out  NUM_PROC  one-hot grant; the granted engine drives eng_word while its bit is high
- eng_word  in  27  {x[26:17], y[16:8], itr[7:0]} from the granted engine
- frame_start  in  1  single-cycle pulse from the coordinate generator; clears the pixel counter
- ram_wr_en  out  1  frame-buffer write strobe
- ram_addr  out  ADDR_W  frame-buffer address
- ram_data  out  8  iteration count to write
- frame_done  out  1  single-cycle pulse when the last pixel of a frame is written
- coord_err  out  1  sticky flag: a result with out-of-range x or y was dropped
- pix_count  out  ADDR_W  pixels written in the current frame

Behaviour:
- Reset (async, iRST_N=0):
  - req_ack=0, ram_wr_en=0, ram_addr=0, ram_data=0, frame_done=0, coord_err=0, pix_count=0.
  - State IDLE; round-robin pointer last=NUM_PROC-1, so engine 0 has top priority first.
  - Reset mid-transfer abandons the transfer; no write is issued.
- FSM states: IDLE, GRANT, WRITE.
  - IDLE: if any engine_req bit is set, select winner, go to GRANT; else stay.
  - GRANT (1 cycle):
    - req_ack has exactly the winner bit high.
    - eng_word is registered at the end of the cycle.
    - last <= winner.
  - WRITE (1 cycle):
    - req_ack=0.
    - ram_wr_en=1 for one cycle with the registered address and data, unless the coordinate is invalid.
    - Arbitration also runs in this cycle: go to GRANT if an eligible request exists, else go to IDLE.
- Round-robin selection:
  - Search starts at index last+1, wrapping modulo NUM_PROC.
  - The first set request wins.
  - In WRITE the just-granted engine's bit is masked, because its request may still be visible for one cycle.
- Throughput: one result every 2 cycles under continuous requests.
- Latency: request seen in IDLE → ack next cycle → write strobe the cycle after that.
- Address arithmetic:
  - ram_addr = x + y*H_RES, computed in the GRANT→WRITE register stage, full ADDR_W width, no truncation for legal coordinates.
  - ram_data = itr.
- Invalid coordinate (x>=H_RES or y>=V_RES):
  - No write: ram_wr_en stays 0.
  - coord_err is set and stays set until reset.
  - pix_count does not advance.
- Pixel counter:
  - Increments on each issued write.
  - When a write occurs with pix_count = H_RES*V_RES-1: frame_done pulses in the same cycle as that ram_wr_en, and pix_count wraps to 0.
- frame_start:
  - Synchronously clears pix_count to 0.
  - If it coincides with a write, that write counts as the first pixel of the new frame (pix_count=1), and no frame_done is generated from the old count.
- No request is ever acked twice without an intervening WRITE. req_ack is never multi-hot.

Test Plan:
- Reset, then a single request: engine_req=0x004 with eng_word x=5, y=2, itr=0x3C.
  - Required: req_ack=0x004 for exactly one cycle.
  - Next cycle: ram_wr_en=1, ram_addr=1285, ram_data=0x3C.
  - pix_count becomes 1.
- All 12 engines requesting continuously, each dropping its request the cycle after its ack.
  - Required grant order: 0,1,2,...,11.
  - One write every 2 cycles; no grant is repeated; req_ack is always one-hot.
- Fairness with last=3 and engine_req=0x009 (engines 0 and 3) held high.
  - Required: engine 0 is granted before engine 3 is re-granted.
  - Grants then alternate 0,3,0,3.
- Boundary values:
  - x=639, y=479: required ram_addr=307199.
  - x=640, y=0: required no ram_wr_en, coord_err=1 and sticky, pix_count unchanged.
- Frame counting: preload via 307199 valid writes, then one more write.
  - Required: frame_done high in the same cycle as the 307200th write, and pix_count=0 afterwards.
  - Repeat with frame_start coincident with a write: required pix_count=1 and no frame_done.
- Assert iRST_N=0 during GRANT.
  - Required: req_ack=0 immediately (async); no write after release.
  - After release, first grant goes to the lowest-indexed requester.
